// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the blocks it sequences.
// The sequencer takes the master modport; the consumer of its resets takes slave.
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    localparam int SW = $clog2(NUM_STAGES + 1);

    logic                  soft_reset_req;
    logic [NUM_STAGES-1:0] stage_ready;
    logic [NUM_STAGES-1:0] reset_out;
    logic                  seq_done;
    logic [SW-1:0]         seq_stage;

    modport master (
        input  soft_reset_req,
        input  stage_ready,
        output reset_out,
        output seq_done,
        output seq_stage
    );

    modport slave (
        output soft_reset_req,
        output stage_ready,
        input  reset_out,
        input  seq_done,
        input  seq_stage
    );
endinterface

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in index order after a hold period and per-stage delays.
// Define RESET_SEQ_ACK_EN to make each release wait for that stage's stage_ready.
module reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DELAY = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    reset_sequencer_if.master bus
);
    localparam int SW   = $clog2(NUM_STAGES + 1);
    localparam int CMAX = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
`ifdef RESET_SEQ_ACK_EN
    localparam logic [SW-1:0] ALL_STAGES = SW'(NUM_STAGES);
`endif

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
`ifdef RESET_SEQ_ACK_EN
        S_WAIT_ACK = 2'd2,
`endif
        S_DONE    = 2'd3
    } state_t;

    state_t                r_state, w_state_next;
    logic [CW-1:0]         r_count, w_count_next;
    logic [NUM_STAGES-1:0] r_reset_out, w_reset_out_next;
    logic                  r_seq_done, w_seq_done_next;
    logic [SW-1:0]         r_seq_stage, w_seq_stage_next;

    logic [NUM_STAGES-1:0] w_stage_mask;
    logic                  w_release;
    logic                  w_last;
`ifdef RESET_SEQ_ACK_EN
    logic [NUM_STAGES-1:0] w_ack_mask;
    logic                  w_ack;
`endif

    // One-hot decode of seq_stage keeps every bit select in range.
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        assign w_stage_mask[gi] = (r_seq_stage == SW'(gi));
`ifdef RESET_SEQ_ACK_EN
        assign w_ack_mask[gi]   = (r_seq_stage == SW'(gi + 1));
`endif
    end

    assign w_release = (r_state == S_RELEASE) && (r_count == STAGE_LAST);
    assign w_last    = (r_seq_stage == LAST_STAGE);
`ifdef RESET_SEQ_ACK_EN
    // Only the stage released most recently may acknowledge.
    assign w_ack     = |(bus.stage_ready & w_ack_mask);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_HOLD;
            r_count     <= '0;
            r_reset_out <= '1;
            r_seq_done  <= 1'b0;
            r_seq_stage <= '0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_reset_out <= w_reset_out_next;
            r_seq_done  <= w_seq_done_next;
            r_seq_stage <= w_seq_stage_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        if (bus.soft_reset_req) begin
            w_state_next = S_HOLD;
            w_count_next = '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_count == HOLD_LAST) begin
                        w_state_next = S_RELEASE;
                        w_count_next = '0;
                    end else begin
                        w_count_next = r_count + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (w_release) begin
                        w_count_next = '0;
`ifdef RESET_SEQ_ACK_EN
                        w_state_next = S_WAIT_ACK;
`else
                        w_state_next = w_last ? S_DONE : S_RELEASE;
`endif
                    end else begin
                        w_count_next = r_count + 1'b1;
                    end
                end
`ifdef RESET_SEQ_ACK_EN
                S_WAIT_ACK: begin
                    if (w_ack) begin
                        w_count_next = '0;
                        w_state_next = (r_seq_stage == ALL_STAGES) ? S_DONE : S_RELEASE;
                    end
                end
`endif
                S_DONE: begin
                    w_state_next = S_DONE;
                end
                default: begin
                    w_state_next = S_HOLD;
                    w_count_next = '0;
                end
            endcase
        end
    end

    // Soft request takes priority, so a release scheduled on the same edge is dropped.
    always_comb begin
        w_reset_out_next = r_reset_out;
        w_seq_done_next  = r_seq_done;
        w_seq_stage_next = r_seq_stage;
        if (bus.soft_reset_req) begin
            w_reset_out_next = '1;
            w_seq_done_next  = 1'b0;
            w_seq_stage_next = '0;
        end else begin
            case (r_state)
                S_RELEASE: begin
                    if (w_release) begin
                        w_reset_out_next = r_reset_out & ~w_stage_mask;
                        w_seq_stage_next = r_seq_stage + 1'b1;
`ifndef RESET_SEQ_ACK_EN
                        w_seq_done_next  = w_last;
`endif
                    end
                end
`ifdef RESET_SEQ_ACK_EN
                S_WAIT_ACK: begin
                    if (w_ack && (r_seq_stage == ALL_STAGES)) begin
                        w_seq_done_next = 1'b1;
                    end
                end
`endif
                default: begin
                    w_seq_done_next = r_seq_done;
                end
            endcase
        end
    end

    assign bus.reset_out = r_reset_out;
    assign bus.seq_done  = r_seq_done;
    assign bus.seq_stage = r_seq_stage;
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues expected outputs tagged with
// an edge number, a negedge monitor compares them as the DUT reaches that edge.
module tb_reset_sequencer;
    logic clk;
    logic reset;
    int   cyc;
    int   base;
    int   n_vec;
    int   n_err;

    typedef struct {
        int         cyc;
        logic [3:0] ro;
        logic       done;
        logic [2:0] st;
        string      tag;
    } exp_t;

    exp_t q[$];

    // Feature-off schedule, edges counted from the last edge with reset/soft request active.
    int         tn[11]  = '{1, 16, 23, 24, 31, 32, 39, 40, 47, 48, 55};
    logic [3:0] tro[11] = '{4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hC, 4'hC, 4'h8, 4'h8, 4'h0, 4'h0};
    logic       tdn[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    logic [2:0] tst[11] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4};

    reset_sequencer_if #(.NUM_STAGES(4)) bus ();

    reset_sequencer #(
        .NUM_STAGES (4),
        .STAGE_DELAY(8),
        .HOLD_CYCLES(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic push(input int c, input logic [3:0] ro, input logic d,
                        input logic [2:0] st, input string tag);
        exp_t e;
        e.cyc  = c;
        e.ro   = ro;
        e.done = d;
        e.st   = st;
        e.tag  = tag;
        q.push_back(e);
    endtask

    task automatic push_sched(input int b, input int maxn, input string tag);
        for (int i = 0; i < 11; i++) begin
            if (tn[i] <= maxn) push(b + tn[i], tro[i], tdn[i], tst[i], tag);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every queued expectation at the negedge of its edge number.
    initial begin
        exp_t e;
        n_vec = 0;
        n_err = 0;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_vec++;
                if (e.cyc < cyc) begin
                    n_err++;
                    $display("FAIL %s: check for edge %0d missed (now %0d)", e.tag, e.cyc, cyc);
                end else if (bus.reset_out !== e.ro || bus.seq_done !== e.done ||
                             bus.seq_stage !== e.st) begin
                    n_err++;
                    $display("FAIL %s @edge %0d: got reset_out=%b seq_done=%b seq_stage=%0d, expected reset_out=%b seq_done=%b seq_stage=%0d",
                             e.tag, e.cyc, bus.reset_out, bus.seq_done, bus.seq_stage,
                             e.ro, e.done, e.st);
                end else begin
                    $display("chk %s @edge %0d: reset_out=%b seq_done=%b seq_stage=%0d ok",
                             e.tag, e.cyc, bus.reset_out, bus.seq_done, bus.seq_stage);
                end
            end
        end
    end

    initial begin
        int c;
        reset              = 1'b1;
        bus.soft_reset_req = 1'b0;
        bus.stage_ready    = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        push(cyc, 4'hF, 1'b0, 3'd0, "in_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        base  = cyc;

`ifndef RESET_SEQ_ACK_EN
        // Boot, then asynchronous reset between edges 35 and 36.
        push_sched(base, 34, "boot");
        wait_until(base + 35);
        #2;
        reset = 1'b1;
        push(cyc, 4'hF, 1'b0, 3'd0, "async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        base  = cyc;
        push_sched(base, 99, "after_async");
        wait_until(base + 56);

        // Soft request held for five edges while DONE.
        bus.soft_reset_req = 1'b1;
        c = cyc;
        push(c + 1, 4'hF, 1'b0, 3'd0, "soft_first");
        push(c + 3, 4'hF, 1'b0, 3'd0, "soft_held");
        wait_until(c + 5);
        bus.soft_reset_req = 1'b0;
        base = c + 5;
        push_sched(base, 31, "after_soft");

        // Soft request coinciding with the stage-1 release.
        wait_until(base + 31);
        bus.soft_reset_req = 1'b1;
        push(base + 32, 4'hF, 1'b0, 3'd0, "soft_vs_release");
        wait_until(base + 32);
        bus.soft_reset_req = 1'b0;
        base = cyc;
        push_sched(base, 99, "after_collision");
        wait_until(base + 56);
`else
        // Acknowledges arrive late, stage 3 acknowledge withheld to gate seq_done.
        push(base + 23, 4'hF, 1'b0, 3'd0, "ack_late");
        push(base + 24, 4'hE, 1'b0, 3'd1, "ack_late");
        push(base + 34, 4'hE, 1'b0, 3'd1, "ack_late");
        push(base + 42, 4'hE, 1'b0, 3'd1, "ack_late");
        push(base + 43, 4'hC, 1'b0, 3'd2, "ack_late");
        push(base + 51, 4'hC, 1'b0, 3'd2, "ack_late");
        push(base + 52, 4'h8, 1'b0, 3'd3, "ack_late");
        push(base + 60, 4'h8, 1'b0, 3'd3, "ack_late");
        push(base + 61, 4'h0, 1'b0, 3'd4, "ack_late");
        push(base + 70, 4'h0, 1'b0, 3'd4, "ack_late");
        push(base + 71, 4'h0, 1'b1, 3'd4, "ack_late");
        wait_until(base + 34);
        bus.stage_ready = 4'b0001;
        wait_until(base + 43);
        bus.stage_ready = 4'b0011;
        wait_until(base + 52);
        bus.stage_ready = 4'b0111;
        wait_until(base + 70);
        bus.stage_ready = 4'b1111;
        wait_until(base + 75);

        // All acknowledges high before the sequence starts.
        reset = 1'b1;
        @(posedge clk);
        #1;
        push(cyc, 4'hF, 1'b0, 3'd0, "in_reset2");
        @(posedge clk);
        #1;
        reset = 1'b0;
        base  = cyc;
        push(base + 23, 4'hF, 1'b0, 3'd0, "ack_tied");
        push(base + 24, 4'hE, 1'b0, 3'd1, "ack_tied");
        push(base + 32, 4'hE, 1'b0, 3'd1, "ack_tied");
        push(base + 33, 4'hC, 1'b0, 3'd2, "ack_tied");
        push(base + 41, 4'hC, 1'b0, 3'd2, "ack_tied");
        push(base + 42, 4'h8, 1'b0, 3'd3, "ack_tied");
        push(base + 50, 4'h8, 1'b0, 3'd3, "ack_tied");
        push(base + 51, 4'h0, 1'b0, 3'd4, "ack_tied");
        push(base + 52, 4'h0, 1'b1, 3'd4, "ack_tied");
        wait_until(base + 60);
`endif

        for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            $display("FAIL drain: %0d checks still pending, required 0", q.size());
            n_err += q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
